// File: rtl/gcbp_subimage_sequencer.sv
// GCBP sub-image sequencer: follows the active sub-image row window from line pulses,
// turns GCBP line words into one-hot BRAM writes and rotates the triple-buffered frame slots.
module gcbp_subimage_sequencer #(
   parameter int C_NUM_VERT_SUBIMAGES = 4,
   parameter int C_NUM_HORI_SUBIMAGES = 4,
   parameter int C_SUBIMAGE_HEIGHT    = 64,
   parameter int C_EDGE_GAP           = 46,
   parameter int C_INTER_GAP          = 44,
   parameter int C_LINES_PER_FRAME    = 480,
   parameter int C_DATA_WIDTH         = 128,
   parameter int C_ADDR_BITS          = 9,
   localparam int C_HW = $clog2(C_NUM_HORI_SUBIMAGES + 1),
   localparam int C_VW = $clog2(C_NUM_VERT_SUBIMAGES + 1),
   localparam int C_NW = C_NUM_VERT_SUBIMAGES * C_NUM_HORI_SUBIMAGES
)(
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_new_frame,
   input  logic                    i_line_done,
   input  logic                    i_line_valid,
   input  logic [C_DATA_WIDTH-1:0] i_line_data,
   input  logic [C_HW-1:0]         i_hori_idx,
   output logic [C_ADDR_BITS-1:0]  o_bram_write_addr,
   output logic [C_DATA_WIDTH-1:0] o_bram_write_data,
   output logic [C_NW-1:0]         o_bram_write_enable,
   output logic [C_VW-1:0]         o_vert_idx,
   output logic                    o_in_window,
   output logic                    o_frame_done,
   output logic                    o_frame_err,
   output logic [1:0]              o_next_frame_loc,
   output logic [1:0]              o_curr_frame_loc,
   output logic [1:0]              o_prev_frame_loc
);
   localparam int C_LW = $clog2(C_LINES_PER_FRAME + 1);
   localparam int C_RW = (C_SUBIMAGE_HEIGHT > 1) ? $clog2(C_SUBIMAGE_HEIGHT) : 1;
   localparam int C_EW = $clog2(C_NW + 1) + 1;

   typedef enum logic [1:0] {S_IDLE, S_GAP, S_WINDOW, S_FRAME_END} state_t;

   state_t           r_state;
   logic [C_LW-1:0]  r_line;
   logic [C_RW-1:0]  r_row_line;

   logic [C_LW-1:0]  w_line_inc;
   logic [31:0]      w_win_start;
   logic             w_enter_win;
   logic             w_row_end;
   logic             w_last_row;
   logic             w_hori_ok;
   logic [C_NW-1:0]  w_onehot;

   assign w_line_inc  = (r_line == C_LW'(C_LINES_PER_FRAME - 1)) ? r_line : r_line + C_LW'(1);
   // In a gap the next window to open always belongs to the current o_vert_idx.
   assign w_win_start = 32'(C_EDGE_GAP)
                      + 32'(o_vert_idx) * 32'(C_SUBIMAGE_HEIGHT + C_INTER_GAP);
   assign w_enter_win = (32'(w_line_inc) == w_win_start);
   assign w_row_end   = (r_row_line == C_RW'(C_SUBIMAGE_HEIGHT - 1));
   assign w_last_row  = (o_vert_idx == C_VW'(C_NUM_VERT_SUBIMAGES - 1));
   assign w_hori_ok   = ({1'b0, i_hori_idx} < (C_HW + 1)'(C_NUM_HORI_SUBIMAGES));
   assign w_onehot    = C_NW'(1) << (C_EW'(o_vert_idx) * C_EW'(C_NUM_HORI_SUBIMAGES)
                                     + C_EW'(i_hori_idx));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state          <= S_IDLE;
         r_line           <= '0;
         r_row_line       <= '0;
         o_vert_idx       <= '0;
         o_in_window      <= 1'b0;
         o_frame_done     <= 1'b0;
         o_frame_err      <= 1'b0;
         o_next_frame_loc <= 2'd0;
         o_curr_frame_loc <= 2'd1;
         o_prev_frame_loc <= 2'd2;
      end else begin
         o_frame_done <= 1'b0;
         if (i_new_frame) begin
            r_line      <= '0;
            r_row_line  <= '0;
            o_vert_idx  <= '0;
            r_state     <= (C_EDGE_GAP == 0) ? S_WINDOW : S_GAP;
            o_in_window <= (C_EDGE_GAP == 0);
            // Only a completed frame may retire its slot; a short one is overwritten in place.
            if (r_state == S_FRAME_END) begin
               o_next_frame_loc <= o_prev_frame_loc;
               o_curr_frame_loc <= o_next_frame_loc;
               o_prev_frame_loc <= o_curr_frame_loc;
            end else if (r_state != S_IDLE) begin
               o_frame_err <= 1'b1;
            end
         end else if (i_line_done && r_state != S_IDLE) begin
            r_line <= w_line_inc;
            case (r_state)
               S_GAP: begin
                  if (w_enter_win) begin
                     r_state     <= S_WINDOW;
                     o_in_window <= 1'b1;
                  end
               end
               S_WINDOW: begin
                  if (w_row_end) begin
                     r_row_line <= '0;
                     if (w_last_row) begin
                        r_state      <= S_FRAME_END;
                        o_in_window  <= 1'b0;
                        o_frame_done <= 1'b1;
                     end else begin
                        o_vert_idx <= o_vert_idx + C_VW'(1);
                        if (C_INTER_GAP != 0) begin
                           r_state     <= S_GAP;
                           o_in_window <= 1'b0;
                        end
                     end
                  end else begin
                     r_row_line <= r_row_line + C_RW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Write port samples the pre-update counters, so a word arriving with i_line_done
   // lands on the line that is ending.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_bram_write_enable <= '0;
         o_bram_write_addr   <= '0;
         o_bram_write_data   <= '0;
      end else if (r_state == S_WINDOW && i_line_valid && w_hori_ok) begin
         o_bram_write_enable <= w_onehot;
         o_bram_write_addr   <= C_ADDR_BITS'(o_next_frame_loc) * C_ADDR_BITS'(C_SUBIMAGE_HEIGHT)
                              + C_ADDR_BITS'(r_row_line);
         o_bram_write_data   <= i_line_data;
      end else begin
         o_bram_write_enable <= '0;
      end
   end

endmodule

// File: doc/gcbp_subimage_sequencer.md
# gcbp_subimage_sequencer

Parametrised successor to the fixed four-row GCBP sub-image tracker. It counts lines internally from the frame-start pulse and tracks which vertical sub-image row window is active, with configurable geometry. It turns per-line GCBP words from the line generator into registered, one-hot BRAM-array writes. It owns the triple-buffer frame rotation and flags short frames, which hold the rotation.

## Interface
- C_NUM_VERT_SUBIMAGES, 4: sub-image rows per frame (V), ≥1
- C_NUM_HORI_SUBIMAGES, 4: sub-images per row (H), ≥1
- C_SUBIMAGE_HEIGHT, 64: lines per sub-image (S)
- C_EDGE_GAP, 46: lines from frame top to row 0 (E)
- C_INTER_GAP, 44: lines between rows (G)
- C_LINES_PER_FRAME, 480: L; require 2E+(V-1)G+VS ≤ L
- C_DATA_WIDTH, 128: width of a GCBP line word
- C_ADDR_BITS, 9: BRAM address width; require 3S ≤ 2^C_ADDR_BITS
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_new_frame  in  1  one-cycle frame-start pulse
- i_line_done  in  1  one-cycle end-of-line pulse
- i_line_valid  in  1  i_line_data/i_hori_idx valid this cycle
- i_line_data  in  C_DATA_WIDTH  GCBP word for one sub-image line
- i_hori_idx  in  CLogB2(H)  horizontal sub-image index of i_line_data
- o_bram_write_addr  out  C_ADDR_BITS  write address
- o_bram_write_data  out  C_DATA_WIDTH  write data
- o_bram_write_enable  out  V*H  one-hot write enable
- o_vert_idx  out  CLogB2(V)  current row index
- o_in_window  out  1  current line lies inside a row window
- o_frame_done  out  1  one-cycle pulse: last row's final line ended
- o_frame_err  out  1  sticky: a frame started before the previous one completed
- o_next_frame_loc / o_curr_frame_loc / o_prev_frame_loc  out  2 each  buffer slot (0..2) of each frame type

## Operation
- Line counter r_line (CLogB2(L) bits) and row line counter r_row_line (0..S-1).
- FSM states:
  - S_IDLE: out of reset; only i_new_frame leaves it.
  - S_GAP: inside an edge or inter-row gap.
  - S_WINDOW: inside a row window.
  - S_FRAME_END: after the last row.
- i_new_frame, from any state:
  - Action: r_line←0, r_row_line←0, o_vert_idx←0.
  - Next state: S_WINDOW if E=0, else S_GAP.
  - Takes priority over a simultaneous i_line_done.
- i_line_done: r_line increments, saturating at L-1. Window for row r spans lines E+r(S+G) to E+r(S+G)+S-1.
  - S_GAP→S_WINDOW when the incremented r_line equals a window start.
  - S_WINDOW: r_row_line increments. After line S-1 ends: r_row_line←0, then:
    - r<V-1: o_vert_idx increments; next state S_GAP, or S_WINDOW if G=0.
    - r=V-1: next state S_FRAME_END, o_frame_done pulses.
  - S_FRAME_END holds until i_new_frame.
- Writes, only in S_WINDOW with i_line_valid=1 and i_hori_idx<H:
  - o_bram_write_enable bit (o_vert_idx*H + i_hori_idx) set.
  - o_bram_write_addr = o_next_frame_loc*S + r_row_line.
  - o_bram_write_data = i_line_data.
  - Otherwise the enable is all-zero; addr/data hold their last values.
- Frame rotation on i_new_frame:
  - Previous frame completed (S_FRAME_END reached since the last i_new_frame): prev←curr, curr←next, next←old prev.
  - Otherwise: no rotation, o_frame_err set; the same next slot is rewritten.
  - First i_new_frame after reset (from S_IDLE): no rotation, no error.
- o_frame_err clears only on reset.

## Timing
- Reset (async assert, sync-safe deassert):
  - State S_IDLE; all counters 0.
  - o_bram_write_enable=0, o_bram_write_addr=0, o_bram_write_data=0.
  - o_vert_idx=0, o_in_window=0, o_frame_done=0, o_frame_err=0.
  - next/curr/prev loc = 0/1/2.
- All outputs registered.
- Write outputs appear 1 cycle after the qualifying i_line_valid. Address and enable use the state and counters sampled in that same cycle.
- i_line_valid coincident with i_line_done is written to the ending line. The update to r_row_line/o_vert_idx takes effect the next cycle.
- o_in_window, o_vert_idx and frame locs update 1 cycle after the causing pulse.
- o_frame_done is high exactly 1 cycle, 1 cycle after the final i_line_done.
- Reset mid-frame abandons the frame; nothing partial is preserved.
- i_line_done in S_IDLE is ignored.

## Test plan
- Defaults, full 480-line frame, 4 valid words per line (h=0..3):
  - Writes occur only on lines 46–109, 154–217, 262–325, 370–433 (1024 writes total).
  - Row 1 line 0, h=2: enable bit 6, addr 0*64+0.
  - o_frame_done pulses once, after line 433 ends.
- Three complete frames:
  - Locs next/curr/prev after each i_new_frame: 0/1/2 (first), 2/0/1, 1/2/0.
  - Frame 3 row-0 line-5 writes go to addr 69.
- Short frame (i_new_frame at line 200):
  - o_frame_err=1, locs unchanged.
  - Following frame writes to the same next slot.
- i_new_frame and i_line_done in the same cycle while in S_WINDOW: r_line=0, state S_GAP, no increment.
- Reset asserted at line 300 mid-write:
  - Enable drops to 0 immediately; locs return to 0/1/2.
  - Next i_new_frame causes no rotation and no error.
- Config V=2, H=2, S=8, E=0, G=4, L=24:
  - Windows on lines 0–7 and 12–19.
  - i_hori_idx=3 is ignored.
  - Addr span 0..23 across the three slots.
